// File: rtl/exposure_readout_timer.sv
// Exposure/readout timing source: holds the exposure setting, produces the
// exposure countdown and steps the readout sub-state sequence.
module exposure_readout_timer #(
    parameter int unsigned TICK_DIV = 200,
    parameter int unsigned DWELL    = 2,
    parameter int unsigned EXP_MIN  = 2,
    parameter int unsigned EXP_MAX  = 30,
    parameter int unsigned EXP_RST  = 2
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Exp_inc,
    input  logic       i_Exp_dec,
    input  logic [1:0] i_Main_FSM,
    output logic [4:0] o_count_time,
    output logic [2:0] o_RD_FSM,
    output logic [4:0] o_Exp_setting
);

    localparam int unsigned EXP_W   = 5;
    localparam int unsigned PRE_W   = 8;
    localparam int unsigned DWELL_W = 4;
    localparam int unsigned STEP_W  = 4;
    localparam int unsigned MAIN_W  = 2;

    localparam logic [STEP_W-1:0]  LAST_STEP = STEP_W'(8);
    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [DWELL_W-1:0] DWL_LAST  = DWELL_W'(DWELL - 1);

    typedef enum logic [MAIN_W-1:0] {
        MAIN_IDLE     = 2'b00,
        MAIN_EXPOSURE = 2'b01,
        MAIN_READOUT  = 2'b10,
        MAIN_ALT_IDLE = 2'b11
    } main_e;

    typedef enum logic [2:0] {
        RD_INIT    = 3'b000,
        RD_NRE_1   = 3'b001,
        RD_ADC_1   = 3'b010,
        RD_NOTHING = 3'b011,
        RD_NRE_2   = 3'b100,
        RD_ADC_2   = 3'b101,
        RD_END     = 3'b110
    } rd_e;

    logic [EXP_W-1:0]   exp_setting_q, exp_setting_d;
    logic [EXP_W-1:0]   count_q, count_d;
    rd_e                rd_q, rd_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [MAIN_W-1:0]  prev_main_q;
    logic               inc_q, dec_q;

    logic inc_edge_c, dec_edge_c, is_idle_c, is_exp_c, is_rd_c;

    // Fixed readout order; NRE phases bracket each ADC phase.
    function automatic rd_e step_to_rd(input logic [STEP_W-1:0] step);
        rd_e rd;
        case (step)
            STEP_W'(0): rd = RD_INIT;
            STEP_W'(1): rd = RD_NRE_1;
            STEP_W'(2): rd = RD_ADC_1;
            STEP_W'(3): rd = RD_NRE_1;
            STEP_W'(4): rd = RD_NOTHING;
            STEP_W'(5): rd = RD_NRE_2;
            STEP_W'(6): rd = RD_ADC_2;
            STEP_W'(7): rd = RD_NRE_2;
            default:    rd = RD_END;
        endcase
        return rd;
    endfunction

    assign inc_edge_c = i_Exp_inc & ~inc_q;
    assign dec_edge_c = i_Exp_dec & ~dec_q;
    assign is_exp_c   = (i_Main_FSM == MAIN_EXPOSURE);
    assign is_rd_c    = (i_Main_FSM == MAIN_READOUT);
    assign is_idle_c  = (i_Main_FSM == MAIN_IDLE) || (i_Main_FSM == MAIN_ALT_IDLE);

    // Exposure setting: button edges honoured only while idle, simultaneous edges cancel.
    always_comb begin
        exp_setting_d = exp_setting_q;
        if (is_idle_c) begin
            if (inc_edge_c && !dec_edge_c && (exp_setting_q < EXP_W'(EXP_MAX))) begin
                exp_setting_d = exp_setting_q + EXP_W'(1);
            end else if (dec_edge_c && !inc_edge_c && (exp_setting_q > EXP_W'(EXP_MIN))) begin
                exp_setting_d = exp_setting_q - EXP_W'(1);
            end
        end
    end

    // Countdown: tracks the setting while idle, reloads on exposure entry, saturates at 0.
    always_comb begin
        count_d = count_q;
        pre_d   = '0;
        if (is_idle_c) begin
            count_d = exp_setting_q;
        end else if (is_exp_c) begin
            if (prev_main_q != MAIN_EXPOSURE) begin
                count_d = exp_setting_q;
            end else if (pre_q == PRE_LAST) begin
                if (count_q != '0) begin
                    count_d = count_q - EXP_W'(1);
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    // Readout sequencer: restarts on entry, parks on END, clears whenever not in readout.
    always_comb begin
        step_d  = '0;
        dwell_d = '0;
        rd_d    = RD_INIT;
        if (is_rd_c && (prev_main_q == MAIN_READOUT)) begin
            step_d  = step_q;
            dwell_d = dwell_q;
            rd_d    = rd_q;
            if (step_q != LAST_STEP) begin
                if (dwell_q == DWL_LAST) begin
                    dwell_d = '0;
                    step_d  = step_q + STEP_W'(1);
                    rd_d    = step_to_rd(step_q + STEP_W'(1));
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            exp_setting_q <= EXP_W'(EXP_RST);
            count_q       <= EXP_W'(EXP_RST);
            rd_q          <= RD_INIT;
            pre_q         <= '0;
            dwell_q       <= '0;
            step_q        <= '0;
            prev_main_q   <= MAIN_IDLE;
            inc_q         <= 1'b0;
            dec_q         <= 1'b0;
        end else begin
            exp_setting_q <= exp_setting_d;
            count_q       <= count_d;
            rd_q          <= rd_d;
            pre_q         <= pre_d;
            dwell_q       <= dwell_d;
            step_q        <= step_d;
            prev_main_q   <= i_Main_FSM;
            inc_q         <= i_Exp_inc;
            dec_q         <= i_Exp_dec;
        end
    end

    assign o_Exp_setting = exp_setting_q;
    assign o_count_time  = count_q;
    assign o_RD_FSM      = rd_q;

endmodule

// File: tb/tb_exposure_readout_timer.sv
// Scoreboard bench for exposure_readout_timer with TICK_DIV=2, DWELL=2.
module tb_exposure_readout_timer;

    logic       clk;
    logic       rst_n;
    logic       exp_inc;
    logic       exp_dec;
    logic [1:0] main_fsm;
    logic [4:0] count_time;
    logic [2:0] rd_fsm;
    logic [4:0] exp_setting;

    int checks   = 0;
    int failures = 0;
    int model_set;

    typedef struct {
        bit         chk_set;
        logic [4:0] set;
        bit         chk_cnt;
        logic [4:0] cnt;
        bit         chk_rd;
        logic [2:0] rd;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    logic [2:0] rd_seq [9] = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd5, 3'd4, 3'd6};

    exposure_readout_timer #(
        .TICK_DIV(2),
        .DWELL   (2),
        .EXP_MIN (2),
        .EXP_MAX (30),
        .EXP_RST (2)
    ) dut (
        .i_Clock      (clk),
        .i_Reset      (rst_n),
        .i_Exp_inc    (exp_inc),
        .i_Exp_dec    (exp_dec),
        .i_Main_FSM   (main_fsm),
        .o_count_time (count_time),
        .o_RD_FSM     (rd_fsm),
        .o_Exp_setting(exp_setting)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    function automatic exp_t ex(input bit cs, input int s, input bit cc, input int c,
                                input bit cr, input int r, input string tag);
        exp_t e;
        e.chk_set = cs;
        e.set     = 5'(s);
        e.chk_cnt = cc;
        e.cnt     = 5'(c);
        e.chk_rd  = cr;
        e.rd      = 3'(r);
        e.tag     = tag;
        return e;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic cyc(input logic inc, input logic dec, input logic [1:0] main, input exp_t e);
        exp_t got;
        @(negedge clk);
        exp_inc  = inc;
        exp_dec  = dec;
        main_fsm = main;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'(0), 32'(1));
        end else begin
            got = sb_q.pop_front();
            if (got.chk_set) check_val({got.tag, "_set"}, 32'(exp_setting), 32'(got.set));
            if (got.chk_cnt) check_val({got.tag, "_cnt"}, 32'(count_time), 32'(got.cnt));
            if (got.chk_rd)  check_val({got.tag, "_rd"},  32'(rd_fsm),     32'(got.rd));
        end
    endtask

    task automatic idle_pulse(input bit up);
        int nxt;
        if (up) nxt = (model_set < 30) ? model_set + 1 : 30;
        else    nxt = (model_set > 2)  ? model_set - 1 : 2;
        cyc(up, !up, 2'b00, ex(1, nxt, 1, model_set, 1, 0, up ? "inc" : "dec"));
        model_set = nxt;
        cyc(1'b0, 1'b0, 2'b00, ex(1, model_set, 1, model_set, 1, 0, "follow"));
    endtask

    initial begin
        rst_n    = 1'b0;
        exp_inc  = 1'b0;
        exp_dec  = 1'b0;
        main_fsm = 2'b00;
        model_set = 2;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_hold_set", 32'(exp_setting), 32'(2));
        check_val("rst_hold_cnt", 32'(count_time),  32'(2));
        check_val("rst_hold_rd",  32'(rd_fsm),      32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 2'b00, ex(1, 2, 1, 2, 1, 0, "post_rst"));

        for (int i = 0; i < 30; i++) idle_pulse(1'b1);
        check_val("sat_max", 32'(exp_setting), 32'(30));
        for (int i = 0; i < 40; i++) idle_pulse(1'b0);
        check_val("sat_min", 32'(exp_setting), 32'(2));

        // Held level counts once.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 2'b00, ex(1, 3, 0, 0, 1, 0, "hold_inc"));
        end
        model_set = 3;
        cyc(1'b0, 1'b0, 2'b00, ex(1, 3, 1, 3, 1, 0, "hold_rel"));

        cyc(1'b1, 1'b1, 2'b00, ex(1, 3, 1, 3, 1, 0, "both"));
        cyc(1'b0, 1'b0, 2'b00, ex(1, 3, 1, 3, 1, 0, "both_rel"));
        idle_pulse(1'b1);

        // Exposure with setting 4; inc edges must be ignored.
        for (int k = 0; k < 16; k++) begin
            cyc((k % 2) == 1, 1'b0, 2'b01,
                ex(1, 4, 1, (k < 8) ? 4 - k / 2 : 0, 1, 0, "expo"));
        end

        // Direct exposure -> readout; full sequence then END held.
        for (int k = 0; k < 36; k++) begin
            cyc(1'b0, 1'b0, 2'b10,
                ex(1, 4, 1, 0, 1, (k < 16) ? rd_seq[k / 2] : 6, "rdout"));
        end
        cyc(1'b0, 1'b0, 2'b00, ex(1, 4, 1, 4, 1, 0, "rd_exit"));

        // Abort at NOTHING, then restart from INIT.
        for (int k = 0; k < 9; k++) begin
            cyc(1'b0, 1'b0, 2'b10, ex(0, 0, 1, 4, 1, rd_seq[k / 2], "rd_a"));
        end
        check_val("at_nothing", 32'(rd_fsm), 32'(3));
        cyc(1'b0, 1'b0, 2'b00, ex(0, 0, 0, 0, 1, 0, "abort"));
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 1'b0, 2'b10, ex(0, 0, 0, 0, 1, rd_seq[k / 2], "rd_re"));
        end

        // Main state 11 behaves as idle.
        cyc(1'b0, 1'b0, 2'b11, ex(1, 4, 1, 4, 1, 0, "alt_idle"));
        cyc(1'b1, 1'b0, 2'b11, ex(1, 5, 1, 4, 1, 0, "alt_inc"));
        cyc(1'b0, 1'b0, 2'b11, ex(1, 5, 1, 5, 1, 0, "alt_follow"));
        cyc(1'b0, 1'b1, 2'b11, ex(1, 4, 1, 5, 1, 0, "alt_dec"));
        cyc(1'b0, 1'b0, 2'b00, ex(1, 4, 1, 4, 1, 0, "alt_back"));
        model_set = 4;

        for (int i = 0; i < 8; i++) idle_pulse(1'b1);

        // Exposure from 12 down to 10, then asynchronous reset.
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0, 2'b01, ex(1, 12, 1, 12 - k / 2, 1, 0, "expo12"));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_set", 32'(exp_setting), 32'(2));
        check_val("arst_cnt", 32'(count_time),  32'(2));
        check_val("arst_rd",  32'(rd_fsm),      32'(0));
        @(negedge clk);
        main_fsm = 2'b00;
        rst_n    = 1'b1;
        cyc(1'b0, 1'b0, 2'b00, ex(1, 2, 1, 2, 1, 0, "arst_rel"));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exposure_readout_timer.md
Name: exposure_readout_timer

Overview:
- Timing source directly upstream of the exposure/readout control FSM.
- Holds the user exposure setting (2..30 ms), adjusted by increase/decrease buttons while idle, and produces the exposure countdown consumed as i_count_time.
- During readout it steps the 3-bit readout sub-state sequence consumed as i_RD_FSM.
- Follows the main FSM state it receives back from the control FSM.

Parameters:
- TICK_DIV, 200, clock cycles per exposure time unit (1 ms at the 200 kHz system clock); 8-bit counter, legal range 1..255.
- DWELL, 2, clock cycles each readout sub-state is held; legal range 1..15.
- EXP_MIN, 2, minimum exposure setting.
- EXP_MAX, 30, maximum exposure setting.
- EXP_RST, 2, exposure setting after reset.

Ports:
- i_Clock  in  1  system clock, rising edge.
- i_Reset  in  1  asynchronous, active-low reset.
- i_Exp_inc  in  1  exposure increase request; level, synchronous.
- i_Exp_dec  in  1  exposure decrease request; level, synchronous.
- i_Main_FSM  in  2  main state from the control FSM: 00 IDLE, 01 EXPOSURE, 10 READOUT, 11 treated as IDLE.
- o_count_time  out  5  remaining exposure time units.
- o_RD_FSM  out  3  readout sub-state: 000 INIT, 001 NRE_1, 010 ADC_1, 011 NOTHING, 100 NRE_2, 101 ADC_2, 110 END.
- o_Exp_setting  out  5  current exposure setting.

Behaviour:
- Reset (i_Reset=0, asynchronous):
  - o_Exp_setting=EXP_RST, o_count_time=EXP_RST, o_RD_FSM=INIT.
  - Prescaler=0, dwell counter=0, step index=0, previous-main register=IDLE, button edge registers=0.
- Registered outputs throughout; effects appear one clock after the sampled input.
- Exposure setting:
  - Rising edges of i_Exp_inc and i_Exp_dec are detected internally; a held level counts once.
  - Edges are acted on only when i_Main_FSM is IDLE; otherwise they are discarded.
  - An inc edge adds 1, saturating at EXP_MAX. A dec edge subtracts 1, saturating at EXP_MIN.
  - Inc and dec edges in the same cycle: no change.
- Countdown:
  - In IDLE (or 11): o_count_time follows o_Exp_setting each cycle; prescaler held at 0.
  - EXPOSURE entry (i_Main_FSM=01 and previous!=01): o_count_time loads o_Exp_setting and the prescaler clears.
  - While in EXPOSURE: the prescaler counts 0..TICK_DIV-1. When it wraps, o_count_time decrements by 1, saturating at 0; it never wraps.
  - First decrement is TICK_DIV cycles after the entry load.
  - In READOUT: o_count_time holds its value (normally 0).
- Readout sequencer, 9 steps in fixed order: INIT, NRE_1, ADC_1, NRE_1, NOTHING, NRE_2, ADC_2, NRE_2, END.
  - READOUT entry (i_Main_FSM=10 and previous!=10): step index=0, dwell counter=0, o_RD_FSM=INIT.
  - Each step is held DWELL cycles, then advances.
  - END is held indefinitely while i_Main_FSM remains READOUT.
  - Any cycle with i_Main_FSM!=READOUT: o_RD_FSM=INIT and step index=0, including an abort mid-sequence.
  - Re-entering READOUT restarts the sequence from INIT.
- Direct EXPOSURE<->READOUT jumps apply the entry rules above.
- Reset asserted mid-exposure or mid-readout returns all state to reset values immediately.

Test Plan:
- Reset low for 2 cycles, then release -> o_Exp_setting=2, o_count_time=2, o_RD_FSM=000.
- In IDLE, pulse i_Exp_inc 30 times -> setting saturates at 30. Pulse i_Exp_dec 40 times -> saturates at 2. Hold inc for 10 cycles -> exactly +1. Inc and dec together -> unchanged.
- With TICK_DIV=2 and setting=4, drive i_Main_FSM=01:
  - o_count_time=4 the cycle after entry, then 3,2,1,0 at 2-cycle intervals.
  - Holds 0 thereafter.
  - Inc pulses during exposure leave the setting at 4.
- With DWELL=2, drive i_Main_FSM=10 -> o_RD_FSM goes 000,001,010,001,011,100,101,100, each for 2 cycles, then 110 held for 20 cycles.
- Abort readout mid-sequence (set i_Main_FSM=00 while at 011), then return to 10 -> o_RD_FSM=000 next cycle and the sequence restarts from INIT. i_Main_FSM=11 behaves as IDLE.
- Assert reset during exposure with o_count_time=10 -> outputs return to reset values asynchronously; setting reverts to 2.
